immgen_arbiter: RTL and testbench
=================================

Name: immgen_arbiter

Overview:
- Shares the single combinational immediate generator among N_REQ requesters (per-core decode stages) in the Xenyx-4 multicore processor.
- Arbitrates requests round-robin and drives the winner's instruction into the shared generator from a register.
- Captures the resulting immediate and returns it to the winner over a valid/ready response channel.
- One transaction is in flight at a time. It is sequenced by a 3-state FSM.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester index; must equal clog2(N_REQ).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  N_REQ  bit i: requester i presents an instruction.
- req_instr  input  32*N_REQ  requester i's instruction is bits [32*i+31:32*i].
- req_grant  output  N_REQ  one-hot; bit i high means requester i's request is accepted this cycle.
- gen_instruction  output  32  registered instruction driven to the shared immediate generator.
- gen_immediate  input  32  combinational result returned by the shared immediate generator.
- rsp_valid  output  1  a response is available.
- rsp_id  output  ID_W  index of the requester that owns the response.
- rsp_immediate  output  32  captured immediate.
- rsp_ready  input  1  consumer accepts the response.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, any state, including mid-transaction):
  - state=IDLE, rr_ptr=0.
  - gen_instruction=0, rsp_immediate=0, rsp_id=0, rsp_valid=0.
  - req_grant=0 while rst is high.
  - An in-flight transaction is dropped with no response.
- FSM states: IDLE, GEN, RESP.
- IDLE:
  - Arbitration: the winner is the first i with req_valid[i]=1, searching from rr_ptr upward modulo N_REQ.
  - req_grant is combinational. It is one-hot for the winner, and 0 when no request is valid or the state is not IDLE.
  - On the edge where any grant is high: gen_instruction<=winner's req_instr; rsp_id<=winner; rr_ptr<=(winner+1) mod N_REQ; state->GEN.
  - No valid request: hold state, rr_ptr unchanged.
- GEN:
  - gen_instruction is stable for the full cycle, so the generator settles within it.
  - On the edge: rsp_immediate<=gen_immediate; rsp_valid<=1; state->RESP.
- RESP:
  - rsp_valid=1; rsp_id and rsp_immediate held stable.
  - On an edge with rsp_ready=1: rsp_valid<=0; state->IDLE.
  - With rsp_ready=0: hold indefinitely. No new grants are issued while in RESP.
- Latency and throughput:
  - Grant edge T -> rsp_valid high after edge T+1.
  - Earliest next grant is the cycle after response acceptance.
  - Best-case throughput: one transaction per 3 cycles.
- Handshake rules:
  - A requester holds req_valid and req_instr until it sees its grant bit; the transfer occurs on that edge.
  - req_valid may drop before grant without penalty.
  - Instruction contents changing after grant have no effect; the value captured in the register is used.
- Fairness:
  - A continuously requesting requester is granted within N_REQ transactions.
  - rr_ptr wraps from N_REQ-1 to 0.
- gen_instruction is not cleared on return to IDLE; it retains the last issued instruction.
- The block performs no width conversion; the 32-bit immediate passes through unmodified.

Test Plan:
- Single request: reset, then req_valid=0001, req_instr[0]=0x00500093. Required: req_grant=0001 in the first IDLE cycle; gen_instruction=0x00500093 the next cycle. With the bench generator model returning 0x00000005, rsp_valid=1 two cycles after grant, rsp_id=0, rsp_immediate=0x00000005.
- Round-robin under full load: req_valid=1111 held, rsp_ready=1 tied. Required grant order: 0,1,2,3,0,... with rr_ptr wrap 3->0, and one grant every 3 cycles.
- Backpressure: response pending with rsp_ready=0 for 10 cycles and req_valid=0110. Required: rsp_valid, rsp_id and rsp_immediate stable; req_grant=0 throughout. After rsp_ready=1, the next grant goes to the requester selected from rr_ptr.
- Sign-extended value passthrough: instruction 0xFFF00093, generator model returns 0xFFFFFFFF. Required: rsp_immediate=0xFFFFFFFF.
- Reset mid-operation: assert rst asynchronously between clock edges while in GEN. Required: busy=0, rsp_valid=0 and gen_instruction=0 immediately. After release, the first grant with req_valid=1111 goes to requester 0.
- Early withdrawal: requester 2 pulses req_valid while requester 1 is being served. Required: no grant is issued to 2 and rr_ptr is unaffected by 2.

Source files
------------

// File: rtl/immgen_arbiter.sv
// rtl/immgen_arbiter.sv - round-robin arbiter sharing one immediate generator among requesters
module immgen_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_instr,
  output logic [N_REQ-1:0]     req_grant,
  output logic [31:0]          gen_instruction,
  input  logic [31:0]          gen_immediate,
  output logic                 rsp_valid,
  output logic [ID_W-1:0]      rsp_id,
  output logic [31:0]          rsp_immediate,
  input  logic                 rsp_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_q, rr_d;
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     imm_q, imm_d;
  logic [ID_W-1:0] id_q, id_d;
  logic            valid_q, valid_d;

  // One extra bit so rr_q + offset never overflows before the modulo wrap.
  logic [ID_W:0]   cand;
  logic [ID_W:0]   rr_next_w;
  logic            win_found;
  logic [ID_W-1:0] win_idx;
  logic [ID_W-1:0] rr_next;

  // Round-robin search: first valid requester at or after rr_q, wrapping at N_REQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(N_REQ)) begin
        cand = cand - (ID_W+1)'(N_REQ);
      end
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next round.
  always_comb begin
    rr_next_w = {1'b0, win_idx} + (ID_W+1)'(1);
    if (rr_next_w >= (ID_W+1)'(N_REQ)) begin
      rr_next_w = '0;
    end
    rr_next = rr_next_w[ID_W-1:0];
  end

  // Grant is combinational, only offered in IDLE and suppressed while reset is held.
  always_comb begin
    req_grant = '0;
    if (state_q == IDLE && win_found && !rst) begin
      req_grant[win_idx] = 1'b1;
    end
  end

  // Next-state and datapath capture for the IDLE -> GEN -> RESP sequence.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    instr_d = instr_q;
    imm_d   = imm_q;
    id_d    = id_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          instr_d = req_instr[32*int'(win_idx) +: 32];
          id_d    = win_idx;
          rr_d    = rr_next;
          state_d = GEN;
        end
      end
      GEN: begin
        // instr_q has been stable all cycle, so the generator output is settled.
        imm_d   = gen_immediate;
        valid_d = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset drops any in-flight transaction without a response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= '0;
      instr_q <= '0;
      imm_q   <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      instr_q <= instr_d;
      imm_q   <= imm_d;
      id_q    <= id_d;
      valid_q <= valid_d;
    end
  end

  assign gen_instruction = instr_q;
  assign rsp_immediate   = imm_q;
  assign rsp_id          = id_q;
  assign rsp_valid       = valid_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_immgen_arbiter.sv
// tb/tb_immgen_arbiter.sv - self-checking bench for immgen_arbiter
module tb_immgen_arbiter;
  localparam int N = 4;
  localparam int W = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [32*N-1:0]  req_instr;
  logic [N-1:0]     req_grant;
  logic [31:0]      gen_instruction;
  logic [31:0]      gen_immediate;
  logic             rsp_valid;
  logic [W-1:0]     rsp_id;
  logic [31:0]      rsp_immediate;
  logic             rsp_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int m_rr   = 0;

  immgen_arbiter #(.N_REQ(N), .ID_W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_instr(req_instr),
    .req_grant(req_grant), .gen_instruction(gen_instruction),
    .gen_immediate(gen_immediate), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_immediate(rsp_immediate), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Generator model: I-type immediate, sign-extended bits [31:20].
  assign gen_immediate = {{20{gen_instruction[31]}}, gen_instruction[31:20]};

  function automatic logic [31:0] model_imm(input logic [31:0] ins);
    return $signed(ins) >>> 20;
  endfunction

  function automatic int model_winner(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_rr + k) % N]) return (m_rr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [32*N-1:0] rand_instrs();
    logic [32*N-1:0] r;
    for (int i = 0; i < N; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Drives one request from an IDLE negedge and records what the DUT shows at each step.
  task automatic txn(input logic [N-1:0] v, input logic [32*N-1:0] ins,
                     output logic [N-1:0] g, output logic [31:0] gi, output logic b,
                     output logic rv, output logic [W-1:0] id, output logic [31:0] imm);
    req_valid = v;
    req_instr = ins;
    rsp_ready = 1'b1;
    #1 g = req_grant;
    @(negedge clk);
    req_valid = '0;
    req_instr = rand_instrs();
    #1 gi = gen_instruction;
    b = busy;
    @(negedge clk);
    #1 rv = rsp_valid;
    id  = rsp_id;
    imm = rsp_immediate;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    req_instr = rand_instrs();
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_grant !== '0) begin errors++; $display("FAIL reset_grant got=%b exp=0", req_grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (gen_instruction !== 32'h0) begin errors++; $display("FAIL reset_gen_instr got=%h exp=0", gen_instruction); end
    checks++; if (rsp_immediate !== 32'h0 || rsp_id !== '0) begin errors++; $display("FAIL reset_rsp got=%h/%0d exp=0/0", rsp_immediate, rsp_id); end
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    m_rr = 0;
  endtask

  task automatic test_single();
    logic [N-1:0] g; logic [31:0] gi, imm; logic b, rv; logic [W-1:0] id;
    logic [32*N-1:0] ins;
    ins = rand_instrs();
    ins[31:0] = 32'h00500093;
    txn(4'b0001, ins, g, gi, b, rv, id, imm);
    m_rr = 1;
    checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", g); end
    checks++; if (gi !== 32'h00500093) begin errors++; $display("FAIL single_gen_instr got=%h exp=00500093", gi); end
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL single_busy got=%b exp=1", b); end
    checks++; if (rv !== 1'b1 || id !== 2'd0) begin errors++; $display("FAIL single_rsp got=%b/%0d exp=1/0", rv, id); end
    checks++; if (imm !== 32'h00000005) begin errors++; $display("FAIL single_imm got=%h exp=00000005", imm); end
  endtask

  task automatic test_round_robin();
    logic [32*N-1:0] ins;
    int grants = 0, last = -1, w, exp_id;
    logic [31:0] exp_imm;
    ins = rand_instrs();
    req_instr = ins;
    req_valid = '1;
    rsp_ready = 1'b1;
    exp_id = 0; exp_imm = '0;
    for (int cyc = 0; cyc < 60 && grants < 9; cyc++) begin
      #1;
      if (rsp_valid) begin
        checks++; if (rsp_id !== W'(exp_id) || rsp_immediate !== exp_imm) begin
          errors++; $display("FAIL rr_rsp got=%0d/%h exp=%0d/%h", rsp_id, rsp_immediate, exp_id, exp_imm);
        end
      end
      if (req_grant !== '0) begin
        w = model_winner(req_valid);
        checks++; if (req_grant !== N'(1 << w)) begin errors++; $display("FAIL rr_order got=%b exp_idx=%0d", req_grant, w); end
        if (last >= 0) begin
          checks++; if (cyc - last !== 3) begin errors++; $display("FAIL rr_spacing got=%0d exp=3", cyc - last); end
        end
        last = cyc;
        exp_id = w;
        exp_imm = model_imm(ins[32*w +: 32]);
        m_rr = (w + 1) % N;
        grants++;
      end
      @(negedge clk);
    end
    checks++; if (grants !== 9) begin errors++; $display("FAIL rr_timeout got=%0d grants exp=9", grants); end
    req_valid = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [32*N-1:0] ins;
    logic [31:0] exp_imm;
    int w;
    ins = rand_instrs();
    req_instr = ins;
    req_valid = 4'b0001;
    rsp_ready = 1'b0;
    #1;
    checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL bp_first_grant got=%b exp=0001", req_grant); end
    exp_imm = model_imm(ins[31:0]);
    m_rr = 1;
    @(negedge clk);
    req_valid = 4'b0110;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_immediate !== exp_imm || req_grant !== '0) begin
        errors++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%h/%b exp=1/0/%h/0000", i, rsp_valid, rsp_id, rsp_immediate, req_grant, exp_imm);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    w = model_winner(4'b0110);
    checks++; if (req_grant !== N'(1 << w)) begin errors++; $display("FAIL bp_next_grant got=%b exp_idx=%0d", req_grant, w); end
    m_rr = (w + 1) % N;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sign();
    logic [N-1:0] g; logic [31:0] gi, imm; logic b, rv; logic [W-1:0] id;
    logic [32*N-1:0] ins;
    int r;
    r = $urandom_range(0, N-1);
    ins = rand_instrs();
    ins[32*r +: 32] = 32'hFFF00093;
    txn(N'(1 << r), ins, g, gi, b, rv, id, imm);
    m_rr = (r + 1) % N;
    checks++; if (imm !== 32'hFFFFFFFF || id !== W'(r)) begin errors++; $display("FAIL sign_imm got=%h/%0d exp=ffffffff/%0d", imm, id, r); end
  endtask

  task automatic test_random();
    logic [N-1:0] g, v; logic [31:0] gi, imm, slot; logic b, rv; logic [W-1:0] id;
    logic [32*N-1:0] ins;
    int w;
    for (int it = 0; it < 30; it++) begin
      v = N'($urandom_range(0, (1 << N) - 1));
      ins = rand_instrs();
      w = model_winner(v);
      txn(v, ins, g, gi, b, rv, id, imm);
      if (w < 0) begin
        checks++; if (g !== '0 || rv !== 1'b0) begin errors++; $display("FAIL rand_idle it=%0d got=%b/%b exp=0/0", it, g, rv); end
      end else begin
        slot = ins[32*w +: 32];
        m_rr = (w + 1) % N;
        checks++; if (g !== N'(1 << w)) begin errors++; $display("FAIL rand_grant it=%0d got=%b exp_idx=%0d", it, g, w); end
        checks++; if (gi !== slot) begin errors++; $display("FAIL rand_gen_instr it=%0d got=%h exp=%h", it, gi, slot); end
        checks++; if (rv !== 1'b1 || id !== W'(w) || imm !== model_imm(slot)) begin
          errors++; $display("FAIL rand_rsp it=%0d got=%b/%0d/%h exp=1/%0d/%h", it, rv, id, imm, w, model_imm(slot));
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [32*N-1:0] ins;
    ins = rand_instrs();
    req_instr = ins;
    req_valid = '1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || gen_instruction !== 32'h0) begin
      errors++; $display("FAIL mid_reset got=%b/%b/%h exp=0/0/0", busy, rsp_valid, gen_instruction);
    end
    @(negedge clk);
    rst = 1'b0;
    m_rr = 0;
    #1;
    checks++; if (req_grant !== 4'b0001) begin errors++; $display("FAIL mid_reset_grant got=%b exp=0001", req_grant); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (gen_instruction !== ins[31:0]) begin errors++; $display("FAIL mid_reset_instr got=%h exp=%h", gen_instruction, ins[31:0]); end
    m_rr = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_withdrawal();
    logic [32*N-1:0] ins;
    int w;
    ins = rand_instrs();
    req_instr = ins;
    rsp_ready = 1'b1;
    req_valid = 4'b0010;
    #1;
    checks++; if (req_grant !== 4'b0010) begin errors++; $display("FAIL wd_grant1 got=%b exp=0010", req_grant); end
    m_rr = 2;
    @(negedge clk);
    req_valid = 4'b0100;
    #1;
    checks++; if (req_grant !== '0) begin errors++; $display("FAIL wd_pulse_grant got=%b exp=0000", req_grant); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1) begin errors++; $display("FAIL wd_rsp got=%b/%0d exp=1/1", rsp_valid, rsp_id); end
    @(negedge clk);
    #1;
    checks++; if (req_grant !== '0 || busy !== 1'b0) begin errors++; $display("FAIL wd_idle got=%b/%b exp=0000/0", req_grant, busy); end
    req_valid = 4'b1011;
    #1;
    w = model_winner(4'b1011);
    checks++; if (req_grant !== N'(1 << w)) begin errors++; $display("FAIL wd_rr got=%b exp_idx=%0d", req_grant, w); end
    m_rr = (w + 1) % N;
    @(negedge clk);
    req_valid = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_instr = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sign();
    test_random();
    test_reset_mid();
    test_withdrawal();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
